// File: rtl/grf_mp.sv
// -----------------------------------------------------------------------------
// grf_mp -- multi-port general register file for the pipelined CPU.
//
// Two write ports and NREAD combinational read ports. Each read port bypasses
// same-cycle writes. A pending-write scoreboard tells decode which registers
// are still waiting for a result. The storage array has no reset. After reset
// is released, a sweep clears it one entry per cycle, and `ready` rises once
// the sweep is done.
//
// Optional feature: define GRF_TRACE_EN to print one trace line per stored
// write ("time@pc: $reg <= data"). Without it, pc is present but unused.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset (0 = in reset)
//   ready       high once the clear sweep has finished
//   raddr       NREAD packed read addresses, port i = [i*ADDR_W +: ADDR_W]
//   rdata       NREAD packed read data, packed like raddr
//   rbusy       per read port: register has a pending, not-yet-written result
//   wen0/waddr0/wdata0  write port 0 (older stage)
//   wen1/waddr1/wdata1  write port 1 (younger stage, wins on collision)
//   alloc_en/alloc_addr mark a destination register as pending
//   pc          PC of the writing instruction, trace only
//   dbg_state   current FSM state (0 = CLEAR, 1 = RUN)
//
// Handshake: there is none. Reads are combinational. Writes and allocs are
// sampled on every rising edge while in RUN, and are ignored in CLEAR.
// -----------------------------------------------------------------------------
module grf_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      ready,
    input  logic [NREAD*ADDR_W-1:0]   raddr,
    output logic [NREAD*DATA_W-1:0]   rdata,
    output logic [NREAD-1:0]          rbusy,
    input  logic                      wen0,
    input  logic [ADDR_W-1:0]         waddr0,
    input  logic [DATA_W-1:0]         wdata0,
    input  logic                      wen1,
    input  logic [ADDR_W-1:0]         waddr1,
    input  logic [DATA_W-1:0]         wdata1,
    input  logic                      alloc_en,
    input  logic [ADDR_W-1:0]         alloc_addr,
    input  logic [31:0]               pc,
    output logic                      dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                ready_q;
    logic [DEPTH-1:0]    busy_q;
    logic [DEPTH-1:0]    busy_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                run;
    logic                wr0_eff;
    logic                wr1_eff;

    assign run = (state_q == ST_RUN);

    // Port 0 is suppressed when port 1 targets the same address. Address 0
    // is never stored.
    assign wr1_eff = run && wen1 && (waddr1 != '0);
    assign wr0_eff = run && wen0 && (waddr0 != '0) &&
                     !(wen1 && (waddr1 == waddr0));

    // Scoreboard next state. The clear happens before the set, so an alloc
    // beats a write to the same register: the newer instruction owns it.
    always_comb begin
        busy_d = busy_q;
        if (wen0) busy_d[waddr0] = 1'b0;
        if (wen1) busy_d[waddr1] = 1'b0;
        if (alloc_en) busy_d[alloc_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Control FSM: the clear sweep runs first, then normal operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    busy_q <= busy_d;
                end
                default: begin
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end

    // Storage array, deliberately without reset. It is zeroed by the sweep.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) mem_q[cnt_q] <= '0;
        if (wr0_eff) mem_q[waddr0] <= wdata0;
        if (wr1_eff) mem_q[waddr1] <= wdata1;
    end

    // Read ports: r0 reads as zero, then port 1 bypass, then port 0 bypass,
    // then the array.
    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit0;
        logic              hit1;

        assign ra   = raddr[g*ADDR_W +: ADDR_W];
        assign hit0 = wen0 && (waddr0 == ra);
        assign hit1 = wen1 && (waddr1 == ra);

        assign rdata[g*DATA_W +: DATA_W] =
            (!run || (ra == '0)) ? '0     :
            hit1                 ? wdata1 :
            hit0                 ? wdata0 :
                                   mem_q[ra];

        // A result landing this cycle is bypassed, so it never stalls.
        assign rbusy[g] = run && (ra != '0) && busy_q[ra] && !hit0 && !hit1;
    end

    assign ready     = ready_q;
    assign dbg_state = state_q;

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (wr0_eff) $display("%0t@%08h: $%2d <= %08h", $time, pc, waddr0, wdata0);
        if (wr1_eff) $display("%0t@%08h: $%2d <= %08h", $time, pc, waddr1, wdata1);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule
